// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: load-size encodings and default widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package wb_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;
    localparam int CNT_W_DEF = 32;

    typedef logic [1:0] ld_size_t;

    // Size code 3 is reserved and decodes as a word everywhere.
    localparam ld_size_t LD_BYTE = 2'd0;
    localparam ld_size_t LD_HALF = 2'd1;
    localparam ld_size_t LD_WORD = 2'd2;

    // Architectural zero register; writes to it are dropped.
    localparam logic [RA_W_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: picks the byte/half lane out of the dcache word and extends it; flags misalignment.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
//
// Ports: rdata (dcache word), addr_lo (load address bits [1:0]), ld_size (byte/half/word),
//        ld_uns (1 = zero-extend), data (aligned, extended result), mis (misaligned access).
module load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  ld_size_t        ld_size,
    input  logic            ld_uns,
    output logic [XLEN-1:0] data,
    output logic            mis
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        byte_sign;
    logic        half_sign;

    // Byte lane starts at 8*addr_lo, half lane at 16*addr_lo[1].
    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign byte_sign = byte_lane[7] & ~ld_uns;
    assign half_sign = half_lane[15] & ~ld_uns;

    always_comb begin
        data = rdata;
        mis  = 1'b0;
        case (ld_size)
            LD_BYTE: begin
                data = {{(XLEN-8){byte_sign}}, byte_lane};
            end
            LD_HALF: begin
                data = {{(XLEN-16){half_sign}}, half_lane};
                mis  = addr_lo[0];
            end
            default: begin
                // Word, including the reserved code.
                data = rdata;
                mis  = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load/ALU select, register-file write, forwarding and retire count.
// Latency: entry captured at edge N writes the register file combinationally in cycle N..N+1; forward visible one cycle later.
// Backpressure: stall holds the entry and still commits it exactly once; flush kills the incoming entry.
//
// Ports: clk, rst (sync, active-high); in_* (MEM-stage instruction fields), rdata (dcache word for the
//        entry in WB), stall, flush; rf_wen/rf_waddr/rf_wdata (register-file write port);
//        fwd_valid/fwd_rd/fwd_data (previous cycle's write); misalign (pulse); instret (retired count).
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_wb_wen,
    input  logic             in_is_load,
    input  ld_size_t         in_ld_size,
    input  logic             in_ld_uns,
    input  logic [1:0]       in_addr_lo,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [XLEN-1:0]  in_pdata,
    input  logic [XLEN-1:0]  rdata,
    input  logic             stall,
    input  logic             flush,
    output logic             rf_wen,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             misalign,
    output logic [CNT_W-1:0] instret
);

    // MEM/WB pipeline register.
    logic            valid;
    logic            done;
    logic            wb_wen;
    logic            is_load;
    ld_size_t        ld_size;
    logic            ld_uns;
    logic [1:0]      addr_lo;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] pdata;

    logic            commit;
    logic            ld_mis;
    logic            mis;
    logic [XLEN-1:0] ld_data;

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata   (rdata),
        .addr_lo (addr_lo),
        .ld_size (ld_size),
        .ld_uns  (ld_uns),
        .data    (ld_data),
        .mis     (ld_mis)
    );

    // done marks an entry that already committed while held by stall, so a
    // long stall still produces exactly one write and one retirement.
    assign commit   = valid & ~done;
    assign mis      = is_load & ld_mis;
    assign misalign = commit & mis;
    assign rf_wen   = commit & wb_wen & ~mis & (rd != RA_W'(ZERO_REG));
    assign rf_waddr = rd;
    assign rf_wdata = is_load ? ld_data : pdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            done      <= 1'b0;
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
            fwd_data  <= '0;
            instret   <= '0;
        end else begin
            fwd_valid <= rf_wen;
            fwd_rd    <= rf_waddr;
            fwd_data  <= rf_wdata;
            if (commit) begin
                instret <= instret + CNT_W'(1);
            end
            // Stall outranks flush: a held entry must never be killed.
            if (stall) begin
                done <= done | commit;
            end else if (flush) begin
                valid <= 1'b0;
                done  <= 1'b0;
            end else begin
                valid   <= in_valid;
                done    <= 1'b0;
                wb_wen  <= in_wb_wen;
                is_load <= in_is_load;
                ld_size <= in_ld_size;
                ld_uns  <= in_ld_uns;
                addr_lo <= in_addr_lo;
                rd      <= in_rd;
                pdata   <= in_pdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_wb_wen, in_is_load, in_ld_uns;
    logic [1:0]  in_ld_size, in_addr_lo;
    logic [4:0]  in_rd;
    logic [31:0] in_pdata, rdata;
    logic        stall, flush;
    logic        rf_wen, fwd_valid, misalign;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data, instret;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_wb_wen(in_wb_wen), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns), .in_addr_lo(in_addr_lo),
        .in_rd(in_rd), .in_pdata(in_pdata), .rdata(rdata),
        .stall(stall), .flush(flush),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .misalign(misalign), .instret(instret)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction-level reference model.
    // ------------------------------------------------------------------
    typedef struct {
        logic        wen;
        logic        ld;
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  a;
        logic [4:0]  rd;
        logic [31:0] pd;
    } ins_t;

    ins_t        m_ins;
    bit          m_has = 1'b0;
    bit          m_retired = 1'b0;
    logic [31:0] m_cnt = '0;
    bit          m_fwd_v = 1'b0;
    logic [4:0]  m_fwd_rd = '0;
    logic [31:0] m_fwd_d = '0;

    // What retiring instruction i must do given the dcache word w.
    function automatic void expect_ins(input ins_t i, input logic [31:0] w,
                                       output bit we, output bit mis, output logic [31:0] d);
        logic [31:0] v;
        mis = i.ld && ((i.sz == 2'd1 && i.a[0]) || (i.sz >= 2'd2 && i.a != 2'd0));
        we  = i.wen && !mis && (i.rd != 5'd0);
        if (!i.ld) begin
            d = i.pd;
        end else if (i.sz == 2'd0) begin
            v = (w >> (8 * i.a)) & 32'h0000_00FF;
            if (!i.uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
            d = v;
        end else if (i.sz == 2'd1) begin
            v = (w >> (16 * (i.a / 2))) & 32'h0000_FFFF;
            if (!i.uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
            d = v;
        end else begin
            d = w;
        end
    endfunction

    always @(posedge clk) begin
        bit live, we, mis;
        logic [31:0] d;
        live = m_has && !m_retired;
        we = 1'b0; mis = 1'b0; d = '0;
        if (live) expect_ins(m_ins, rdata, we, mis, d);
        if (rst) begin
            m_has = 1'b0; m_retired = 1'b0; m_cnt = '0;
            m_fwd_v = 1'b0; m_fwd_rd = '0; m_fwd_d = '0;
        end else begin
            m_fwd_v = live && we;
            m_fwd_rd = m_ins.rd;
            m_fwd_d = d;
            if (live) begin
                m_cnt = m_cnt + 32'd1;
                m_retired = 1'b1;
            end
            if (stall) begin
                // held, not killed
            end else if (flush) begin
                m_has = 1'b0;
            end else begin
                m_has = in_valid;
                m_retired = 1'b0;
                m_ins = '{in_wb_wen, in_is_load, in_ld_size, in_ld_uns, in_addr_lo, in_rd, in_pdata};
            end
        end
    end

    always @(negedge clk) begin
        bit live, we, mis;
        logic [31:0] d;
        if (chk_en) begin
            live = m_has && !m_retired;
            we = 1'b0; mis = 1'b0; d = '0;
            if (live) expect_ins(m_ins, rdata, we, mis, d);
            check("rf_wen", {31'd0, rf_wen}, {31'd0, we});
            check("misalign", {31'd0, misalign}, {31'd0, mis});
            check("instret", instret, m_cnt);
            check("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_fwd_v});
            if (we) begin
                check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_ins.rd});
                check("rf_wdata", rf_wdata, d);
            end
            if (m_fwd_v) begin
                check("fwd_rd", {27'd0, fwd_rd}, {27'd0, m_fwd_rd});
                check("fwd_data", fwd_data, m_fwd_d);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge, then go idle; the instruction sits in WB afterwards.
    task automatic send(input logic wen, input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [1:0] a, input logic [4:0] rd, input logic [31:0] pd,
                        input logic [31:0] w);
        in_valid = 1'b1; in_wb_wen = wen; in_is_load = ld; in_ld_size = sz;
        in_ld_uns = uns; in_addr_lo = a; in_rd = rd; in_pdata = pd;
        tick();
        in_valid = 1'b0;
        rdata = w;
        #1;
    endtask

    initial begin
        logic [31:0] base;
        rst = 1'b1; in_valid = 1'b0; in_wb_wen = 1'b0; in_is_load = 1'b0;
        in_ld_size = 2'd0; in_ld_uns = 1'b0; in_addr_lo = 2'd0; in_rd = 5'd0;
        in_pdata = '0; rdata = '0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_rf_wen", {31'd0, rf_wen}, 32'd0);
        check("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("reset_instret", instret, 32'd0);

        // ALU write
        send(1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        check("alu_wen", {31'd0, rf_wen}, 32'd1);
        check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h1234_5678);
        check("alu_instret_before", instret, 32'd0);
        tick();
        check("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check("alu_fwd_rd", {27'd0, fwd_rd}, 32'd5);
        check("alu_fwd_data", fwd_data, 32'h1234_5678);
        check("alu_instret_after", instret, 32'd1);

        // Sub-word loads, back to back
        send(1'b1, 1'b1, 2'd0, 1'b0, 2'd3, 5'd1, 32'd0, 32'h80FF_7F01);
        check("lb_a3", rf_wdata, 32'hFFFF_FF80);
        send(1'b1, 1'b1, 2'd0, 1'b1, 2'd3, 5'd2, 32'd0, 32'h80FF_7F01);
        check("lbu_a3", rf_wdata, 32'h0000_0080);
        send(1'b1, 1'b1, 2'd1, 1'b0, 2'd2, 5'd3, 32'd0, 32'h80FF_7F01);
        check("lh_a2", rf_wdata, 32'hFFFF_80FF);
        tick();
        check("loads_instret", instret, 32'd4);

        // Misaligned word load
        send(1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 5'd7, 32'd0, 32'h1111_2222);
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        check("mis_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        check("mis_pulse_end", {31'd0, misalign}, 32'd0);
        check("mis_instret", instret, 32'd5);

        // Write to x0
        send(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 32'hCAFE_F00D, 32'd0);
        check("x0_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        check("x0_instret", instret, 32'd6);

        // Flushed arrival
        flush = 1'b1;
        send(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd9, 32'h0000_0099, 32'd0);
        flush = 1'b0;
        check("flush_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        check("flush_instret", instret, 32'd6);

        // Stall for 3 cycles (with a flush during the stall that must not kill the entry)
        send(1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 5'd10, 32'd0, 32'hABCD_9876);
        stall = 1'b1;
        check("stall_wen_first", {31'd0, rf_wen}, 32'd1);
        check("stall_wdata", rf_wdata, 32'h0000_9876);
        tick();
        flush = 1'b1;
        check("stall_wen_2", {31'd0, rf_wen}, 32'd0);
        tick();
        flush = 1'b0;
        check("stall_wen_3", {31'd0, rf_wen}, 32'd0);
        check("stall_instret", instret, 32'd7);
        tick();
        stall = 1'b0;
        tick();
        check("stall_released_wen", {31'd0, rf_wen}, 32'd0);
        check("stall_released_instret", instret, 32'd7);

        // Sweep every size/offset/extension against the model
        base = 32'h8F7E_6D5C;
        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < 4; a++) begin
                for (int u = 0; u < 2; u++) begin
                    send(1'b1, 1'b1, 2'(s), 1'(u), 2'(a), 5'(1 + s * 8 + a * 2 + u),
                         32'd0, base);
                    base = {base[30:0], base[31]} ^ 32'h0101_0101;
                end
            end
        end
        tick();

        // Reset during a stalled entry
        send(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 5'd12, 32'h5555_AAAA, 32'd0);
        stall = 1'b1;
        check("rst_pre_wen", {31'd0, rf_wen}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wen", {31'd0, rf_wen}, 32'd0);
        check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        check("rst_instret", instret, 32'd0);
        tick();
        stall = 1'b0;
        tick();
        check("rst_no_late_commit", {31'd0, rf_wen}, 32'd0);
        check("rst_instret_after", instret, 32'd0);
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
